// File: rtl/disp_scan.sv
// Four-digit multiplexed seven-segment scanner with a load-strobed shadow register.
// Optional macro DISP_ZERO_BLANK_EN blanks leading-zero digits (digit0 is never blanked).
module disp_scan #(
  parameter int DIV_W = 17
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] hex,
  input  logic [3:0]  point,
  input  logic        load,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT
);

  logic [DIV_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [15:0]      shadow_hex;
  logic [3:0]       shadow_pt;
  logic [3:0]       cur_nib;
  logic [6:0]       cur_seg;
  logic             slot_start;
  logic             slot_end;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef DISP_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble are zero.
  function automatic logic leading_zero(input logic [15:0] h, input logic [1:0] idx);
    logic z;
    case (idx)
      2'd3:    z = (h[15:12] == 4'h0);
      2'd2:    z = (h[15:8] == 8'h00);
      2'd1:    z = (h[15:4] == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  assign slot_start = (refresh_cnt == '0);
  assign slot_end   = (refresh_cnt == '1);

  always_comb begin
    cur_nib = shadow_hex[digit_idx*4 +: 4];
`ifdef DISP_ZERO_BLANK_EN
    cur_seg = leading_zero(shadow_hex, digit_idx) ? 7'h7F : seg_decode(cur_nib);
`else
    cur_seg = seg_decode(cur_nib);
`endif
  end

  // Output register stage: one cycle behind counter, index and shadow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      shadow_hex  <= 16'h0000;
      shadow_pt   <= 4'h0;
      AN          <= 4'hF;
      SEGMENT     <= 8'hFF;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      if (slot_end)
        digit_idx <= digit_idx + 2'd1;
      if (load) begin
        shadow_hex <= hex;
        shadow_pt  <= point;
      end
      if (slot_start) begin
        AN      <= 4'hF;
        SEGMENT <= 8'hFF;
      end else begin
        AN      <= ~(4'b0001 << digit_idx);
        SEGMENT <= {~shadow_pt[digit_idx], cur_seg};
      end
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DIV_W=2 (4-cycle slots: one dead cycle + three lit cycles).
module tb_disp_scan;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] hex;
  logic [3:0]  point;
  logic        load;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;

  int checks = 0;
  int errors = 0;

  disp_scan #(.DIV_W(2)) dut (
    .clk(clk),
    .rstn(rstn),
    .hex(hex),
    .point(point),
    .load(load),
    .AN(AN),
    .SEGMENT(SEGMENT)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [3:0] an, input logic [7:0] seg, input string tag);
    checks++;
    assert (AN === an && SEGMENT === seg) else begin
      errors++;
      $error("FAIL %s: AN=%b SEGMENT=%h, expected AN=%b SEGMENT=%h", tag, AN, SEGMENT, an, seg);
    end
  endtask

  task automatic step(input logic [3:0] an, input logic [7:0] seg, input string tag);
    @(posedge clk);
    #1;
    chk(an, seg, tag);
  endtask

  // One full slot: dead cycle then three lit cycles; load pulses on step ld_step (1..4, 0 = none).
  task automatic slot(input logic [3:0] an, input logic [7:0] seg, input int ld_step, input string tag);
    for (int s = 1; s <= 4; s++) begin
      load = (s == ld_step);
      @(posedge clk);
      #1;
      load = 1'b0;
      if (s == 1) chk(4'hF, 8'hFF, {tag, "_dead"});
      else        chk(an, seg, tag);
    end
  endtask

  initial begin
    rstn = 1'b0; hex = 16'h0000; point = 4'h0; load = 1'b0;
    step(4'hF, 8'hFF, "rst0");
    step(4'hF, 8'hFF, "rst1");
    rstn = 1'b1;
    step(4'hF, 8'hFF, "rel_dead");
    step(4'hE, 8'hC0, "rel_d0_a");
    step(4'hE, 8'hC0, "rel_d0_b");
    // Load on the wrap cycle: the new value must appear in the first lit cycle of digit1.
    hex = 16'h1234; point = 4'b0000; load = 1'b1;
    step(4'hE, 8'hC0, "rel_d0_c");
    load = 1'b0;
    slot(4'hD, 8'hB0, 0, "h1234_d1");
    slot(4'hB, 8'hA4, 0, "h1234_d2");
    slot(4'h7, 8'hF9, 0, "h1234_d3");
    hex = 16'hABCF; point = 4'b0100;
    slot(4'hE, 8'h99, 4, "h1234_d0");
    slot(4'hD, 8'hC6, 0, "habcf_d1");
    slot(4'hB, 8'h03, 0, "habcf_d2_dp");
    slot(4'h7, 8'h88, 0, "habcf_d3");
    // Input changes without load must not reach the display.
    hex = 16'h5678; point = 4'b0000;
    slot(4'hE, 8'h8E, 0, "noload_d0");
    slot(4'hD, 8'hC6, 0, "noload_d1");
    slot(4'hB, 8'h82, 1, "h5678_d2");
    slot(4'h7, 8'h92, 0, "h5678_d3");
    slot(4'hE, 8'h80, 0, "h5678_d0");
    slot(4'hD, 8'hF8, 0, "h5678_d1");
    // One-cycle reset in the middle of the digit2 slot.
    step(4'hF, 8'hFF, "d2_dead");
    step(4'hB, 8'h82, "d2_lit");
    rstn = 1'b0;
    step(4'hF, 8'hFF, "midrst");
    rstn = 1'b1;
    step(4'hF, 8'hFF, "midrst_dead");
    step(4'hE, 8'hC0, "midrst_d0_a");
    step(4'hE, 8'hC0, "midrst_d0_b");
    step(4'hE, 8'hC0, "midrst_d0_c");
    hex = 16'h0070; point = 4'b0000;
    slot(4'hD, 8'hC0, 0, "cleared_d1");
`ifdef DISP_ZERO_BLANK_EN
    slot(4'hB, 8'hFF, 1, "h0070_d2");
    slot(4'h7, 8'hFF, 0, "h0070_d3");
`else
    slot(4'hB, 8'hC0, 1, "h0070_d2");
    slot(4'h7, 8'hC0, 0, "h0070_d3");
`endif
    slot(4'hE, 8'hC0, 0, "h0070_d0");
    slot(4'hD, 8'hF8, 0, "h0070_d1");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
